// File: rtl/write_bram_pkg.sv
// write_bram shared types and defaults.
// FSM encoding and width constants.
package write_bram_pkg;

  localparam int DATA_W = 8;
  localparam int ITER_W = 16;
  localparam int WPI_W  = 16;
  localparam int ADDR_W = 16;
  localparam int SLOTS  = 4;
  localparam int SLOT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/write_bram_if.sv
// write_bram config/stream/BRAM bundle.
// master drives config and stream, slave is the block.
interface write_bram_if
  import write_bram_pkg::*;
#(
  parameter int DATA_WIDTH              = DATA_W,
  parameter int LOG_MAX_ITERS           = ITER_W,
  parameter int LOG_MAX_WRITES_PER_ITER = WPI_W,
  parameter int LOG_MAX_ADDRESS         = ADDR_W
);

  logic                               configure;
  logic [LOG_MAX_ITERS-1:0]           num_iters;
  logic [LOG_MAX_WRITES_PER_ITER-1:0] num_writes_per_iter;
  logic [LOG_MAX_ADDRESS-1:0]         base_address;
  logic                               valid_in;
  logic [DATA_WIDTH-1:0]              data_in;
  logic                               avail_out;
  logic [LOG_MAX_ADDRESS-1:0]         address_out;
  logic [DATA_WIDTH-1:0]              data_out;
  logic                               write_out;
  logic                               done;
  logic                               overflow;

  modport master (
    output configure, num_iters, num_writes_per_iter,
    output base_address, valid_in, data_in,
    input  avail_out, address_out, data_out,
    input  write_out, done, overflow
  );

  modport slave (
    input  configure, num_iters, num_writes_per_iter,
    input  base_address, valid_in, data_in,
    output avail_out, address_out, data_out,
    output write_out, done, overflow
  );

endinterface

// File: rtl/write_bram_fifo.sv
// Small power-of-two FIFO with same-cycle push/pop.
// A push while full is taken only if a pop frees the slot.
module wr_fifo #(
  parameter int W      = 8,
  parameter int SLOTS  = 4,
  parameter int SLOT_W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         almost_full,
  output logic         empty
);

  localparam logic [SLOT_W:0] FULL_C = (SLOT_W+1)'(SLOTS);
  localparam logic [SLOT_W:0] AF_C   = (SLOT_W+1)'(SLOTS - 1);

  logic [W-1:0]      mem [SLOTS];
  logic [SLOT_W-1:0] wp;
  logic [SLOT_W-1:0] rp;
  logic [SLOT_W:0]   cnt;
  logic              do_push;
  logic              do_pop;

  assign full        = (cnt == FULL_C);
  assign almost_full = (cnt >= AF_C);
  assign empty       = (cnt == '0);
  assign head        = mem[rp];
  assign do_pop      = pop && !empty;
  assign do_push     = push && (!full || do_pop);

  // storage write, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      cnt <= cnt + (SLOT_W+1)'(do_push)
                 - (SLOT_W+1)'(do_pop);
    end
  end

endmodule

// File: rtl/write_bram.sv
// Stream-to-BRAM writer: FIFO in, windowed writes out.
// Each iteration rewrites base..base+writes-1.
module write_bram
  import write_bram_pkg::*;
#(
  parameter int DATA_WIDTH              = DATA_W,
  parameter int LOG_MAX_ITERS           = ITER_W,
  parameter int LOG_MAX_WRITES_PER_ITER = WPI_W,
  parameter int LOG_MAX_ADDRESS         = ADDR_W,
  parameter int NUM_SLOTS               = SLOTS,
  parameter int LOG_NUM_SLOTS           = SLOT_W
) (
  input logic         clk,
  input logic         rst,
  write_bram_if.slave bus
);

  localparam int IW = LOG_MAX_ITERS;
  localparam int WW = LOG_MAX_WRITES_PER_ITER;
  localparam int AW = LOG_MAX_ADDRESS;

  state_t                state;
  logic [IW-1:0]         iters_left;
  logic [WW-1:0]         writes_left;
  logic [WW-1:0]         writes_cpy;
  logic [AW-1:0]         base_cpy;
  logic [AW-1:0]         addr_r;
  logic [AW-1:0]         addr_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  write_o;
  logic                  ovf_r;
  logic                  avail_q;

  logic [DATA_WIDTH-1:0] head;
  logic                  full;
  logic                  almost_full;
  logic                  empty;
  logic                  pop;
  logic                  cfg_ok;

  assign pop    = (state == RUN) && !empty;
  assign cfg_ok = (bus.num_iters != '0)
               && (bus.num_writes_per_iter != '0);

  wr_fifo #(
    .W      (DATA_WIDTH),
    .SLOTS  (NUM_SLOTS),
    .SLOT_W (LOG_NUM_SLOTS)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (bus.valid_in),
    .pop         (pop),
    .din         (bus.data_in),
    .head        (head),
    .full        (full),
    .almost_full (almost_full),
    .empty       (empty)
  );

  // FSM, window counters and registered BRAM port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      iters_left  <= '0;
      writes_left <= '0;
      writes_cpy  <= '0;
      base_cpy    <= '0;
      addr_r      <= '0;
      addr_o      <= '0;
      data_o      <= '0;
      write_o     <= 1'b0;
      ovf_r       <= 1'b0;
      avail_q     <= 1'b0;
    end else begin
      avail_q <= 1'b1;
      write_o <= pop;
      if (bus.valid_in && full && !pop) ovf_r <= 1'b1;
      if (pop) begin
        addr_o <= addr_r;
        data_o <= head;
      end
      if (bus.configure) begin
        if (cfg_ok) begin
          state       <= RUN;
          iters_left  <= bus.num_iters;
          writes_left <= bus.num_writes_per_iter;
          writes_cpy  <= bus.num_writes_per_iter;
          base_cpy    <= bus.base_address;
          addr_r      <= bus.base_address;
        end else begin
          state <= DONE;
        end
      end else begin
        unique case (state)
          IDLE: state <= IDLE;
          RUN: begin
            if (pop) begin
              if (writes_left == WW'(1)) begin
                if (iters_left == IW'(1)) begin
                  state <= DONE;
                end else begin
                  iters_left  <= iters_left - 1'b1;
                  writes_left <= writes_cpy;
                  addr_r      <= base_cpy;
                end
              end else begin
                writes_left <= writes_left - 1'b1;
                addr_r      <= addr_r + 1'b1;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.avail_out   = avail_q && !almost_full;
  assign bus.address_out = addr_o;
  assign bus.data_out    = data_o;
  assign bus.write_out   = write_o;
  assign bus.done        = (state == DONE);
  assign bus.overflow    = ovf_r;

endmodule
